shift_add_mult: RTL

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_pkg.sv | 18 +
 rtl/shift_add_mult_if.sv | 22 ++
 rtl/shift_add_mult_dp.sv | 62 ++++++
 rtl/shift_add_mult.sv | 94 +++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller states,
// default operand width and a helper for sizing the step counter.
package shift_add_mult_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_mult_if.sv
// Request/result bundle of the multiplier. The requester drives start and
// the operands; the multiplier returns product, done and busy.
interface shift_add_mult_if import shift_add_mult_pkg::*; #(
    parameter int n = N_DEFAULT
);
    logic           start;
    logic [n-1:0]   multiplicand;
    logic [n-1:0]   multiplier;
    logic [2*n-1:0] product;
    logic           done;
    logic           busy;

    modport master (
        output start, multiplicand, multiplier,
        input  product, done, busy
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, done, busy
    );
endinterface

// File: rtl/shift_add_mult_dp.sv
// Datapath of the shift-and-add multiplier: operand register, combined
// accumulator/multiplier shift register, n+1-bit adder and result register.
module shift_add_mult_dp import shift_add_mult_pkg::*; #(
    parameter int n = N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,      // capture operands, clear accumulator
    input  logic           step,      // perform one add-and-shift step
    input  logic           commit,    // capture the result of this step
    input  logic [n-1:0]   a_in,
    input  logic [n-1:0]   b_in,
    output logic [2*n-1:0] product
);

    logic [n-1:0]   mcand_q, mcand_d;
    // Upper half is the running partial sum; lower half starts as the
    // multiplier and is consumed one bit per step from the LSB.
    logic [2*n-1:0] acc_q, acc_d;
    logic [2*n-1:0] product_q, product_d;
    logic [n:0]     sum;
    logic [2*n-1:0] acc_step;

    // One step: conditional add into the upper half, then shift the
    // 2n+1-bit {carry, upper, lower} right by one so the carry is kept.
    always_comb begin
        sum      = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, mcand_q} : {(n+1){1'b0}});
        acc_step = {sum, acc_q[n-1:1]};
    end

    // Next-state selection for operand, accumulator and result registers.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        if (load) begin
            mcand_d = a_in;
            acc_d   = {{n{1'b0}}, b_in};
        end else if (step) begin
            acc_d = acc_step;
        end
        if (commit) begin
            product_d = acc_step;
        end
    end

    // Datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: n add-and-shift steps per operation with
// fixed latency, a one-cycle done pulse and back-to-back restart from DONE.
module shift_add_mult import shift_add_mult_pkg::*; #(
    parameter int n = N_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    shift_add_mult_if.slave bus
);

    localparam int            CW   = cnt_width(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          load, step, commit;

    // Controller next state, step count and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            CALC: begin
                // start is deliberately not looked at here.
                step = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Status outputs are registered, so derive them from the next state.
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // Controller registers, forced to IDLE by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    shift_add_mult_dp #(.n(n)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .commit  (commit),
        .a_in    (bus.multiplicand),
        .b_in    (bus.multiplier),
        .product (bus.product)
    );

    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule
